// File: rtl/word_demux_buf.sv
// word_demux_buf
//   Steers a single 64-bit word stream to one of two consumers, picked per word by
//   i_in_sel. Each destination owns a DEPTH-entry FIFO, so a stalled consumer only
//   blocks words headed for its own queue.
//
// Ports
//   i_clk                 clock, all state updates on the rising edge
//   i_reset               synchronous active-high reset
//   i_flush               synchronous clear of both queues (reset has priority)
//   i_in_valid/o_in_ready producer handshake; i_in_sel picks the queue, i_in_data payload
//   o_outN_valid          queue N non-empty
//   i_outN_ready          consumer N pops the head when valid & ready
//   o_outN_data           head of queue N (first-word-fall-through), '0 when empty
//   o_countN              occupancy of queue N
module word_demux_buf #(
    parameter int unsigned DEPTH = 2
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_flush,
    input  logic                    i_in_valid,
    output logic                    o_in_ready,
    input  logic                    i_in_sel,
    input  logic [63:0]             i_in_data,
    output logic                    o_out0_valid,
    input  logic                    i_out0_ready,
    output logic [63:0]             o_out0_data,
    output logic                    o_out1_valid,
    input  logic                    i_out1_ready,
    output logic [63:0]             o_out1_data,
    output logic [$clog2(DEPTH):0]  o_count0,
    output logic [$clog2(DEPTH):0]  o_count1
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [63:0]   r_mem    [2][DEPTH];
    logic [AW-1:0] r_rd_ptr [2];
    logic [AW-1:0] r_wr_ptr [2];
    logic [CW-1:0] r_count  [2];

    logic       w_clear;
    logic       w_accept;
    logic [1:0] w_out_ready;
    logic [1:0] w_out_valid;
    logic [1:0] w_pop;
    logic [1:0] w_push;
    logic [1:0] w_room;

    always_comb begin
        w_clear     = i_reset | i_flush;
        w_out_ready = {i_out1_ready, i_out0_ready};
        w_out_valid = '0;
        w_pop       = '0;
        w_room      = '0;
        for (int q = 0; q < 2; q++) begin
            w_out_valid[q] = (r_count[q] != '0);
            // A pop in a reset/flush cycle is discarded.
            w_pop[q]       = w_out_valid[q] & w_out_ready[q] & ~w_clear;
            // A full queue still has room when its head leaves this cycle.
            w_room[q]      = (r_count[q] < FULL) | w_pop[q];
        end
        o_in_ready       = ~w_clear & w_room[i_in_sel];
        w_accept         = i_in_valid & o_in_ready;
        w_push           = '0;
        w_push[i_in_sel] = w_accept;
    end

    // Pointers and occupancy. Pointer wrap is free because DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        for (int q = 0; q < 2; q++) begin
            if (w_clear) begin
                r_rd_ptr[q] <= '0;
                r_wr_ptr[q] <= '0;
                r_count[q]  <= '0;
            end else begin
                if (w_push[q]) begin
                    r_wr_ptr[q] <= r_wr_ptr[q] + 1'b1;
                end
                if (w_pop[q]) begin
                    r_rd_ptr[q] <= r_rd_ptr[q] + 1'b1;
                end
                unique case ({w_push[q], w_pop[q]})
                    2'b10:   r_count[q] <= r_count[q] + 1'b1;
                    2'b01:   r_count[q] <= r_count[q] - 1'b1;
                    default: r_count[q] <= r_count[q];
                endcase
            end
        end
    end

    // Storage needs no reset: reads are masked by the valid flag.
    always_ff @(posedge i_clk) begin
        for (int q = 0; q < 2; q++) begin
            if (w_push[q]) begin
                r_mem[q][r_wr_ptr[q]] <= i_in_data;
            end
        end
    end

    always_comb begin
        o_out0_valid = w_out_valid[0];
        o_out1_valid = w_out_valid[1];
        o_out0_data  = w_out_valid[0] ? r_mem[0][r_rd_ptr[0]] : '0;
        o_out1_data  = w_out_valid[1] ? r_mem[1][r_rd_ptr[1]] : '0;
        o_count0     = r_count[0];
        o_count1     = r_count[1];
    end

    a_count0_bound : assert property (@(posedge i_clk) disable iff (i_reset)
        r_count[0] <= FULL);
    a_count1_bound : assert property (@(posedge i_clk) disable iff (i_reset)
        r_count[1] <= FULL);

endmodule

// File: tb/tb_word_demux_buf.sv
// Testbench for word_demux_buf: a queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_word_demux_buf;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_sel = 1'b0;
    logic [63:0]   in_data = '0;
    logic          out0_valid;
    logic          out0_ready = 1'b0;
    logic [63:0]   out0_data;
    logic          out1_valid;
    logic          out1_ready = 1'b0;
    logic [63:0]   out1_data;
    logic [CW-1:0] count0;
    logic [CW-1:0] count1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] mq0[$];
    logic [63:0] mq1[$];
    logic [63:0] log0[$];
    bit          model_live = 1'b0;

    word_demux_buf #(.DEPTH(DEPTH)) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_flush      (flush),
        .i_in_valid   (in_valid),
        .o_in_ready   (in_ready),
        .i_in_sel     (in_sel),
        .i_in_data    (in_data),
        .o_out0_valid (out0_valid),
        .i_out0_ready (out0_ready),
        .o_out0_data  (out0_data),
        .o_out1_valid (out1_valid),
        .i_out1_ready (out1_ready),
        .o_out1_data  (out1_data),
        .o_count0     (count0),
        .o_count1     (count1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: two unbounded queues limited to DEPTH by the acceptance rule.
    always @(posedge clk) begin
        bit p0, p1, room;
        if (reset || flush) begin
            mq0.delete();
            mq1.delete();
            if (reset) model_live = 1'b1;
        end else begin
            p0   = out0_ready && (mq0.size() > 0);
            p1   = out1_ready && (mq1.size() > 0);
            room = in_sel ? (mq1.size() < DEPTH || p1) : (mq0.size() < DEPTH || p0);
            if (p0) void'(mq0.pop_front());
            if (p1) void'(mq1.pop_front());
            if (in_valid && room) begin
                if (in_sel) mq1.push_back(in_data);
                else        mq0.push_back(in_data);
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        bit exp_rdy;
        if (model_live) begin
            exp_rdy = !reset && !flush &&
                      (in_sel ? (mq1.size() < DEPTH || (out1_ready && mq1.size() > 0))
                              : (mq0.size() < DEPTH || (out0_ready && mq0.size() > 0)));
            chk("m_in_ready",   64'(in_ready),   64'(exp_rdy));
            chk("m_out0_valid", 64'(out0_valid), 64'(mq0.size() != 0));
            chk("m_out0_data",  out0_data,       (mq0.size() != 0) ? mq0[0] : 64'h0);
            chk("m_count0",     64'(count0),     64'(mq0.size()));
            chk("m_out1_valid", 64'(out1_valid), 64'(mq1.size() != 0));
            chk("m_out1_data",  out1_data,       (mq1.size() != 0) ? mq1[0] : 64'h0);
            chk("m_count1",     64'(count1),     64'(mq1.size()));
        end
    end

    // Record words actually handed to consumer 0.
    always @(negedge clk) begin
        if (!reset && !flush && out0_valid && out0_ready) log0.push_back(out0_data);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic s, input logic [63:0] d);
        bit acc = 1'b0;
        in_valid = 1'b1;
        in_sel   = s;
        in_data  = d;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            tick();
        end
        in_valid = 1'b0;
        if (!acc) chk("push_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        bit acc;
        int idx;

        // Reset
        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_count0", 64'(count0), 64'd0);
        chk("rst_count1", 64'(count1), 64'd0);
        chk("rst_valid0", 64'(out0_valid), 64'd0);
        chk("rst_data1",  out1_data, 64'h0);
        tick();

        // 1: one word to each consumer
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 64'h1111;
        @(negedge clk);
        chk("t1_ready", 64'(in_ready), 64'd1);
        tick();
        in_sel = 1'b1; in_data = 64'h2222;
        @(negedge clk);
        chk("t1_out0_data", out0_data, 64'h1111);
        chk("t1_count0", 64'(count0), 64'd1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("t1_out1_data", out1_data, 64'h2222);
        chk("t1_count0_drained", 64'(count0), 64'd0);
        tick();
        @(negedge clk);
        chk("t1_count1_drained", 64'(count1), 64'd0);
        tick();

        // 2: fill queue 0, third word blocked, queue 1 still flows
        out0_ready = 1'b0;
        push(1'b0, 64'h10);
        push(1'b0, 64'h20);
        in_valid = 1'b1; in_sel = 1'b0; in_data = 64'h30;
        @(negedge clk);
        chk("t2_count0_full", 64'(count0), 64'd2);
        chk("t2_blocked", 64'(in_ready), 64'd0);
        tick();
        @(negedge clk);
        chk("t2_still_blocked", 64'(in_ready), 64'd0);
        tick();
        in_valid = 1'b0;
        tick();
        push(1'b1, 64'hBEEF);
        @(negedge clk);
        chk("t2_out1_data", out1_data, 64'hBEEF);
        tick();

        // 3: push into full queue 0 while it pops
        log0.delete();
        out0_ready = 1'b1;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 64'h3;
        @(negedge clk);
        chk("t3_ready_full_pop", 64'(in_ready), 64'd1);
        chk("t3_head", out0_data, 64'h10);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("t3_count_kept", 64'(count0), 64'd2);
        tick();
        tick();
        tick();
        chk("t3_pops", 64'(log0.size()), 64'd3);
        if (log0.size() == 3) begin
            chk("t3_pop0", log0[0], 64'h10);
            chk("t3_pop1", log0[1], 64'h20);
            chk("t3_pop2", log0[2], 64'h3);
        end

        // 4: eight words through queue 0 with toggling ready (pointer wrap)
        log0.delete();
        idx = 1;
        for (int c = 0; c < 80 && log0.size() < 8; c++) begin
            out0_ready = c[0];
            in_valid   = (idx <= 8);
            in_sel     = 1'b0;
            in_data    = 64'(idx);
            @(negedge clk);
            acc = in_valid && in_ready;
            tick();
            if (acc) idx++;
        end
        in_valid = 1'b0;
        out0_ready = 1'b1;
        tick();
        chk("t4_pop_count", 64'(log0.size()), 64'd8);
        for (int i = 0; i < 8 && i < log0.size(); i++) begin
            chk("t4_pop_order", log0[i], 64'(i + 1));
        end

        // 5: flush with both queues full
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        push(1'b0, 64'hA1);
        push(1'b0, 64'hA2);
        push(1'b1, 64'hB1);
        push(1'b1, 64'hB2);
        in_valid = 1'b1; in_sel = 1'b0; in_data = 64'h99;
        flush = 1'b1;
        out0_ready = 1'b1;
        @(negedge clk);
        chk("t5_full0", 64'(count0), 64'd2);
        chk("t5_full1", 64'(count1), 64'd2);
        chk("t5_flush_ready", 64'(in_ready), 64'd0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("t5_count0", 64'(count0), 64'd0);
        chk("t5_count1", 64'(count1), 64'd0);
        chk("t5_valid1", 64'(out1_valid), 64'd0);
        chk("t5_data0", out0_data, 64'h0);
        tick();

        // 6: reset mid-stream
        out0_ready = 1'b0;
        push(1'b0, 64'h77);
        @(negedge clk);
        chk("t6_count0_pre", 64'(count0), 64'd1);
        tick();
        log0.delete();
        reset = 1'b1;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 64'h55;
        out0_ready = 1'b1;
        @(negedge clk);
        chk("t6_ready_in_reset", 64'(in_ready), 64'd0);
        tick();
        tick();
        reset = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("t6_count0", 64'(count0), 64'd0);
        chk("t6_valid0", 64'(out0_valid), 64'd0);
        chk("t6_data0", out0_data, 64'h0);
        tick();
        tick();
        tick();
        chk("t6_no_stale_pop", 64'(log0.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
